usq_next_addr: RTL

- Microsequencer next-address stage, directly downstream of the BUT logic on the DPM.
- Merges the microword NEXT field with the BUT-driven low-asserted CS ADDR bits (wired OR into bits 5:0).
- Holds the registered micro-PC that addresses the control store.
- Provides a micro-subroutine return stack and a microtrap entry path that disables BUT contribution on the trap cycle.

---
 rtl/usq_next_addr.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/usq_next_addr.sv
// Microsequencer next-address stage: micro-PC register, BUT address merge,
// micro-subroutine return stack and microtrap entry.
module usq_next_addr #(
    parameter int unsigned      ADDR_W      = 14,
    parameter int unsigned      STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic                             buf_m_clk_l,
    input  logic                             sac_reset_h,
    input  logic                             d_clk_enable_h,
    input  logic [ADDR_W-1:0]                next_addr_h,
    input  logic [5:0]                       but_cs_addr_l,
    input  logic                             sub_call_h,
    input  logic                             sub_ret_h,
    input  logic                             trap_req_h,
    input  logic [ADDR_W-1:0]                trap_vec_h,
    output logic [ADDR_W-1:0]                cs_addr_h,
    output logic                             dis_cs_addr_h,
    output logic                             trap_ack_h,
    output logic [$clog2(STACK_DEPTH):0]     stack_depth_h,
    output logic                             stack_ovf_h,
    output logic                             stack_unf_h
);

    localparam int unsigned PTR_W   = $clog2(STACK_DEPTH);
    localparam int unsigned DEPTH_W = PTR_W + 1;

    logic [ADDR_W-1:0]  cs_addr_q, cs_addr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               ack_q, ack_d;
    logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0]  but_or;
    logic [ADDR_W-1:0]  br;
    logic [ADDR_W-1:0]  inc;
    logic [PTR_W-1:0]   top_ptr;
    logic [ADDR_W-1:0]  top;
    logic               full;
    logic               empty;
    logic               push;
    logic [ADDR_W-1:0]  push_data;
    logic               overwrite;

    // BUT lines are low-asserted and wire-ORed into the low six address bits.
    assign but_or  = {{(ADDR_W-6){1'b0}}, ~but_cs_addr_l};
    assign br      = next_addr_h | but_or;
    assign inc     = cs_addr_q + ADDR_W'(1);
    assign top_ptr = wr_ptr_q - PTR_W'(1);
    assign top     = stack_q[top_ptr];
    assign full    = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty   = (depth_q == '0);

    always_comb begin
        cs_addr_d = cs_addr_q;
        wr_ptr_d  = wr_ptr_q;
        depth_d   = depth_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        ack_d     = 1'b0;
        push      = 1'b0;
        push_data = '0;
        overwrite = 1'b0;
        if (d_clk_enable_h) begin
            if (trap_req_h) begin
                // Push the aborted address so it re-executes on return.
                cs_addr_d = trap_vec_h;
                push      = 1'b1;
                push_data = cs_addr_q;
                ack_d     = 1'b1;
            end else if (sub_call_h && sub_ret_h && !empty) begin
                cs_addr_d = br;
                overwrite = 1'b1;
            end else if (sub_ret_h && !sub_call_h) begin
                if (!empty) begin
                    cs_addr_d = top | but_or;
                    wr_ptr_d  = top_ptr;
                    depth_d   = depth_q - DEPTH_W'(1);
                end else begin
                    cs_addr_d = br;
                    unf_d     = 1'b1;
                end
            end else if (sub_call_h) begin
                cs_addr_d = br;
                push      = 1'b1;
                push_data = inc;
            end else begin
                cs_addr_d = br;
            end

            // A full stack overwrites its oldest entry, which is the slot at wr_ptr.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    depth_d = depth_q + DEPTH_W'(1);
                end
            end
        end
    end

    always_ff @(posedge buf_m_clk_l) begin
        if (sac_reset_h) begin
            cs_addr_q <= RESET_ADDR;
            wr_ptr_q  <= '0;
            depth_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            cs_addr_q <= cs_addr_d;
            wr_ptr_q  <= wr_ptr_d;
            depth_q   <= depth_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            ack_q     <= ack_d;
        end
    end

    // Stack storage needs no reset; only the pointer and depth define validity.
    always_ff @(posedge buf_m_clk_l) begin
        if (!sac_reset_h) begin
            if (push) begin
                stack_q[wr_ptr_q] <= push_data;
            end else if (overwrite) begin
                stack_q[top_ptr] <= inc;
            end
        end
    end

    assign cs_addr_h     = cs_addr_q;
    assign dis_cs_addr_h = trap_req_h;
    assign trap_ack_h    = ack_q;
    assign stack_depth_h = depth_q;
    assign stack_ovf_h   = ovf_q;
    assign stack_unf_h   = unf_q;

endmodule
